cu_ex_seq: RTL and testbench
============================

Name: cu_ex_seq

Overview:
- Parametrised execute-stage sequencer for the core. It replaces the fixed 4-phase counter scheme with a handshake-driven FSM.
- Accepts one decoded op per transaction via valid/ready and selects operand 2 (rs2 or immediate). It resolves operand forwarding from NUM_FWD bypass sources.
- It drives an external ALU through a start/done handshake with a timeout, then holds the result until the downstream stage takes it.

Parameters:
XLEN, 32, datapath width of operands and result
OPW, 5, width of the ALU op code
NUM_FWD, 2, number of forwarding sources (>=1)
ALU_TIMEOUT, 8, max WAIT cycles without alu_done before timeout (>=1)

Ports:
soc_clk  in  1  clock, all logic on rising edge
EX_reset  in  1  synchronous, active-high reset
EX_stall  in  1  freezes acceptance and issue (see Behaviour)
in_valid  in  1  upstream op valid
in_ready  out  1  sequencer can accept an op
rs1_data  in  XLEN  operand 1 from register file
rs2_data  in  XLEN  operand 2 from register file
imm_data  in  XLEN  immediate
op_in  in  OPW  ALU op code
use_imm  in  1  1: operand 2 = imm_data, 0: rs2_data
fwd_en1  in  NUM_FWD  per-source forward-enable for operand 1
fwd_en2  in  NUM_FWD  per-source forward-enable for operand 2 (ignored when use_imm latched 1)
fwd_data  in  NUM_FWD*XLEN  bypass values, source i at [i*XLEN +: XLEN]
alu_start  out  1  one-cycle ALU start pulse
alu_dat1  out  XLEN  ALU operand 1
alu_dat2  out  XLEN  ALU operand 2
alu_op  out  OPW  latched op code
alu_done  in  1  ALU result valid
alu_out  in  XLEN  ALU result
alu_flags  in  4  {overflow, zero, con_met, err}
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
result_data  out  XLEN  result
overflow_flag  out  1  ALU overflow
zero_flag  out  1  ALU zero
condition_met_flag  out  1  branch condition met
error_flag  out  1  ALU error or timeout
timeout_flag  out  1  ALU did not respond within ALU_TIMEOUT

Behaviour:
- Clock and reset: one clock, soc_clk. Reset EX_reset is synchronous, active-high.
- Reset (any state, mid-operation included):
  - State = IDLE.
  - Outputs 0: alu_start, alu_dat1/2, alu_op, res_valid, result_data, all flags.
  - Timeout counter 0; latched operands 0.
  - Reset has priority over every other input.
- All outputs are registered except in_ready, which is combinational: (state==IDLE) && !EX_stall.
- States: IDLE, RESOLVE, ISSUE, WAIT, HOLD.
- IDLE:
  - On in_valid && in_ready, latch rs1_data, rs2_data, imm_data, op_in, use_imm. Go to RESOLVE.
  - No acceptance while EX_stall=1.
- RESOLVE:
  - If EX_stall=1, stay in RESOLVE.
  - Otherwise sample fwd_en1/fwd_en2 and fwd_data in this cycle.
  - Operand 1 = fwd_data of the lowest set bit of fwd_en1, else latched rs1.
  - Operand 2 = latched imm if use_imm, else lowest set bit of fwd_en2, else latched rs2.
  - Load alu_dat1/2 and alu_op, then go to ISSUE.
- ISSUE:
  - alu_start=1 for exactly this cycle.
  - Clear the timeout counter and go to WAIT. EX_stall is ignored.
- WAIT:
  - EX_stall does not pause the ALU or the counter.
  - On alu_done: latch result_data=alu_out, {overflow,zero,condition_met,error}_flag=alu_flags, timeout_flag=0. Set res_valid=1 and go to HOLD.
  - Otherwise increment the counter. After ALU_TIMEOUT consecutive WAIT cycles without alu_done: result_data=0, error_flag=1, timeout_flag=1, other flags 0, res_valid=1, go to HOLD.
  - alu_done in the same cycle the limit is reached: done wins, no timeout.
- HOLD:
  - res_valid and all result outputs stay stable until res_ready=1. EX_stall does not clear them.
  - On res_valid && res_ready: res_valid=0 next cycle, state IDLE. Result and flags keep their last value.
- alu_done outside WAIT (late response after timeout, spurious pulse): ignored, no state change.
- Latency with alu_done asserted one cycle after alu_start:
  - Accept edge T.
  - alu_start high in cycle T+2.
  - res_valid high from T+4.
- Throughput: at most one op in flight; in_ready=0 outside IDLE.
- Widths: counter width $clog2(ALU_TIMEOUT+1). No arithmetic on data; pure selection and registering.

Test Plan:
1. Basic op: reset, then in_valid with rs1=5, imm=7, use_imm=1, op=ADD, no forwarding. ALU model returns 12 one cycle after start, res_ready=1 → res_valid at T+4, result_data=12, all flags 0, back in IDLE at T+5.
2. Forwarding priority: fwd_en1=2'b11, fwd_data={32'hBB,32'hAA}, use_imm=0, fwd_en2=2'b10, rs2=9 in RESOLVE → alu_dat1=32'hAA, alu_dat2=32'hBB. With fwd_en2=0 → alu_dat2=9.
3. Timeout: ALU_TIMEOUT=8, alu_done never asserted → exactly 8 WAIT cycles, then res_valid=1, result_data=0, error_flag=1, timeout_flag=1. A late alu_done in HOLD/IDLE leaves outputs unchanged. Also: alu_done on the 8th WAIT cycle → normal result, timeout_flag=0.
4. Stall: EX_stall=1 in IDLE → in_ready=0, op not accepted. Stall raised in RESOLVE for 3 cycles → alu_start delayed 3 cycles. Stall in HOLD → result_data and res_valid unchanged.
5. Backpressure: res_ready=0 for 5 cycles after result 32'hDEADBEEF → res_valid and result held stable all 5 cycles, in_ready=0. res_ready=1 → IDLE next cycle.
6. Reset mid-op: EX_reset in WAIT, then alu_done next cycle → state IDLE, res_valid=0, all outputs 0, done ignored.

Source files
------------

// File: rtl/cu_ex_seq.sv
// Execute-stage sequencer: accepts one decoded op, resolves bypass operands,
// runs an external ALU over a start/done handshake with timeout, then holds the result.

module cu_ex_fwd_mux #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic [XLEN-1:0]         i_dflt,
  input  logic [NUM_FWD-1:0]      i_en,
  input  logic [NUM_FWD*XLEN-1:0] i_data,
  output logic [XLEN-1:0]         o_sel
);
  // Walk from the top down so the lowest enabled source has the last word.
  always_comb begin
    o_sel = i_dflt;
    for (int i = NUM_FWD-1; i >= 0; i--)
      if (i_en[i]) o_sel = i_data[i*XLEN +: XLEN];
  end
endmodule

module cu_ex_seq #(
  parameter int XLEN        = 32,
  parameter int OPW         = 5,
  parameter int NUM_FWD     = 2,
  parameter int ALU_TIMEOUT = 8
) (
  input  logic                    soc_clk,
  input  logic                    EX_reset,
  input  logic                    EX_stall,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         rs1_data,
  input  logic [XLEN-1:0]         rs2_data,
  input  logic [XLEN-1:0]         imm_data,
  input  logic [OPW-1:0]          op_in,
  input  logic                    use_imm,
  input  logic [NUM_FWD-1:0]      fwd_en1,
  input  logic [NUM_FWD-1:0]      fwd_en2,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  output logic                    alu_start,
  output logic [XLEN-1:0]         alu_dat1,
  output logic [XLEN-1:0]         alu_dat2,
  output logic [OPW-1:0]          alu_op,
  input  logic                    alu_done,
  input  logic [XLEN-1:0]         alu_out,
  input  logic [3:0]              alu_flags,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [XLEN-1:0]         result_data,
  output logic                    overflow_flag,
  output logic                    zero_flag,
  output logic                    condition_met_flag,
  output logic                    error_flag,
  output logic                    timeout_flag
);
  localparam int CW = $clog2(ALU_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(ALU_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_RESOLVE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_rs1, r_rs2, r_imm;
  logic [OPW-1:0]    r_op;
  logic              r_use_imm;
  logic [XLEN-1:0]   w_op1, w_op2, w_fwd2;
  logic [NUM_FWD-1:0] w_en2;
  logic              w_accept, w_last;

  assign in_ready = (r_state == S_IDLE) && !EX_stall;
  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == LIMIT);
  assign w_en2    = r_use_imm ? '0 : fwd_en2;
  assign w_op2    = r_use_imm ? r_imm : w_fwd2;

  cu_ex_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd1 (
    .i_dflt(r_rs1), .i_en(fwd_en1), .i_data(fwd_data), .o_sel(w_op1));
  cu_ex_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd2 (
    .i_dflt(r_rs2), .i_en(w_en2), .i_data(fwd_data), .o_sel(w_fwd2));

  always_ff @(posedge soc_clk)
    if (EX_reset) r_state <= S_IDLE;
    else          r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_RESOLVE;
      S_RESOLVE: if (!EX_stall) w_next = S_ISSUE;
      S_ISSUE:   w_next = S_WAIT;
      S_WAIT:    if (alu_done || w_last) w_next = S_HOLD;
      S_HOLD:    if (res_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge soc_clk) begin
    if (EX_reset) begin
      r_cnt              <= '0;
      r_rs1              <= '0;
      r_rs2              <= '0;
      r_imm              <= '0;
      r_op               <= '0;
      r_use_imm          <= 1'b0;
      alu_start          <= 1'b0;
      alu_dat1           <= '0;
      alu_dat2           <= '0;
      alu_op             <= '0;
      res_valid          <= 1'b0;
      result_data        <= '0;
      overflow_flag      <= 1'b0;
      zero_flag          <= 1'b0;
      condition_met_flag <= 1'b0;
      error_flag         <= 1'b0;
      timeout_flag       <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_rs1     <= rs1_data;
          r_rs2     <= rs2_data;
          r_imm     <= imm_data;
          r_op      <= op_in;
          r_use_imm <= use_imm;
        end
        S_RESOLVE: if (!EX_stall) begin
          alu_dat1  <= w_op1;
          alu_dat2  <= w_op2;
          alu_op    <= r_op;
          alu_start <= 1'b1;
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          // A done arriving on the final allowed cycle beats the timeout.
          if (alu_done) begin
            result_data        <= alu_out;
            overflow_flag      <= alu_flags[3];
            zero_flag          <= alu_flags[2];
            condition_met_flag <= alu_flags[1];
            error_flag         <= alu_flags[0];
            timeout_flag       <= 1'b0;
            res_valid          <= 1'b1;
          end else if (w_last) begin
            result_data        <= '0;
            overflow_flag      <= 1'b0;
            zero_flag          <= 1'b0;
            condition_met_flag <= 1'b0;
            error_flag         <= 1'b1;
            timeout_flag       <= 1'b1;
            res_valid          <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HOLD: if (res_ready) res_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cu_ex_seq.sv
// Scoreboard bench for cu_ex_seq: stimulus pushes expected ALU operands and results,
// an ALU model and a result monitor pop and compare.

module tb_cu_ex_seq;
  localparam int XLEN = 32, OPW = 5, NF = 2;

  logic soc_clk = 1'b0;
  logic EX_reset, EX_stall, in_valid, in_ready;
  logic [XLEN-1:0] rs1_data, rs2_data, imm_data;
  logic [OPW-1:0] op_in;
  logic use_imm;
  logic [NF-1:0] fwd_en1, fwd_en2;
  logic [NF*XLEN-1:0] fwd_data;
  logic alu_start, alu_done;
  logic [XLEN-1:0] alu_dat1, alu_dat2, alu_out;
  logic [OPW-1:0] alu_op;
  logic [3:0] alu_flags;
  logic res_valid, res_ready;
  logic [XLEN-1:0] result_data;
  logic overflow_flag, zero_flag, condition_met_flag, error_flag, timeout_flag;

  always #5 soc_clk = ~soc_clk;

  cu_ex_seq #(.XLEN(XLEN), .OPW(OPW), .NUM_FWD(NF), .ALU_TIMEOUT(8)) dut (
    .soc_clk(soc_clk), .EX_reset(EX_reset), .EX_stall(EX_stall),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_data(imm_data),
    .op_in(op_in), .use_imm(use_imm),
    .fwd_en1(fwd_en1), .fwd_en2(fwd_en2), .fwd_data(fwd_data),
    .alu_start(alu_start), .alu_dat1(alu_dat1), .alu_dat2(alu_dat2), .alu_op(alu_op),
    .alu_done(alu_done), .alu_out(alu_out), .alu_flags(alu_flags),
    .res_valid(res_valid), .res_ready(res_ready), .result_data(result_data),
    .overflow_flag(overflow_flag), .zero_flag(zero_flag),
    .condition_met_flag(condition_met_flag), .error_flag(error_flag),
    .timeout_flag(timeout_flag));

  typedef struct packed { logic [31:0] d1; logic [31:0] d2; logic [4:0] op; } opx_t;
  typedef struct packed { logic [31:0] data; logic [4:0] flg; } res_t; // {ovf,zero,cm,err,tmo}

  opx_t exp_ops[$];
  res_t exp_res[$];
  int n_cmp = 0, n_bad = 0;
  int alu_delay = 1;            // negedges after start before done; <=0 never
  logic [31:0] alu_val = '0;
  logic [3:0]  alu_fv = '0;
  int spur_req = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ALU model: checks operands at start, answers after alu_delay cycles
  initial begin
    int cd, spur_ack;
    opx_t e;
    cd = -1; spur_ack = 0;
    alu_done = 1'b0; alu_out = '0; alu_flags = '0;
    forever begin
      @(negedge soc_clk);
      if (spur_ack != spur_req) begin
        spur_ack = spur_req;
        alu_done = 1'b1; alu_out = 32'h5A5A5A5A; alu_flags = 4'hF;
      end else if (cd == 1) begin
        alu_done = 1'b1; alu_out = alu_val; alu_flags = alu_fv; cd = -1;
      end else begin
        alu_done = 1'b0;
        if (cd > 1) cd--;
      end
      if (alu_start) begin
        if (exp_ops.size() == 0) chk("op_unexpected", 64'd1, 64'd0);
        else begin
          e = exp_ops.pop_front();
          chk("alu_dat1", alu_dat1, e.d1);
          chk("alu_dat2", alu_dat2, e.d2);
          chk("alu_op", alu_op, e.op);
        end
        cd = alu_delay;
      end
    end
  end

  // Result monitor: one compare per accepted result
  initial begin
    res_t r;
    forever begin
      @(negedge soc_clk);
      if (res_valid && res_ready) begin
        if (exp_res.size() == 0) chk("res_unexpected", 64'd1, 64'd0);
        else begin
          r = exp_res.pop_front();
          chk("result_data", result_data, r.data);
          chk("flags", {overflow_flag, zero_flag, condition_met_flag, error_flag, timeout_flag}, r.flg);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  task automatic send(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                      input logic [4:0] op, input logic ui, input logic [1:0] e1,
                      input logic [1:0] e2, input logic [63:0] fd);
    int n;
    n = 0;
    @(negedge soc_clk);
    rs1_data = r1; rs2_data = r2; imm_data = im; op_in = op; use_imm = ui;
    fwd_en1 = e1; fwd_en2 = e2; fwd_data = fd; in_valid = 1'b1;
    while (!in_ready && n < 40) begin @(negedge soc_clk); n++; end
    chk("accept_ready", in_ready, 1'b1);
    @(posedge soc_clk); #1 in_valid = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin @(negedge soc_clk); n++; end while (!alu_start && n < 40);
  endtask

  task automatic wait_rv(output int n);
    n = 0;
    do begin @(negedge soc_clk); n++; end while (!res_valid && n < 40);
  endtask

  task automatic run_op(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                        input logic [4:0] op, input logic ui, input logic [1:0] e1,
                        input logic [1:0] e2, input logic [63:0] fd);
    int n;
    send(r1, r2, im, op, ui, e1, e2, fd);
    wait_start(n);
    wait_rv(n);
    @(negedge soc_clk);
    chk("back_idle", in_ready, 1'b1);
  endtask

  initial begin
    int n, m;
    EX_reset = 1'b1; EX_stall = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
    rs1_data = '0; rs2_data = '0; imm_data = '0; op_in = '0; use_imm = 1'b0;
    fwd_en1 = '0; fwd_en2 = '0; fwd_data = '0;
    repeat (3) @(posedge soc_clk);
    #1 EX_reset = 1'b0;
    @(negedge soc_clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_alu_start", alu_start, 1'b0);
    chk("rst_outs", {alu_dat1, alu_dat2, result_data}, 64'd0);
    chk("rst_flags", {alu_op, overflow_flag, zero_flag, condition_met_flag, error_flag, timeout_flag}, 64'd0);

    // basic op with latency checks
    alu_delay = 1; alu_val = 32'd12; alu_fv = 4'b0000;
    exp_ops.push_back('{32'd5, 32'd7, 5'd0});
    exp_res.push_back('{32'd12, 5'b00000});
    send(32'd5, 32'd0, 32'd7, 5'd0, 1'b1, 2'b00, 2'b00, 64'd0);
    wait_start(n);
    chk("lat_start", n, 2);
    chk("busy_in_ready", in_ready, 1'b0);
    wait_rv(n);
    chk("lat_res", n, 2);
    @(negedge soc_clk);
    chk("basic_idle", in_ready, 1'b1);
    chk("basic_rv_clr", res_valid, 1'b0);

    // forwarding priority
    alu_val = 32'h165; alu_fv = 4'b0010;
    exp_ops.push_back('{32'hAA, 32'hBB, 5'd3});
    exp_res.push_back('{32'h165, 5'b00100});
    run_op(32'd1, 32'd9, 32'd3, 5'd3, 1'b0, 2'b11, 2'b10, {32'hBB, 32'hAA});
    alu_val = 32'd10; alu_fv = 4'b0100;
    exp_ops.push_back('{32'd1, 32'd9, 5'd4});
    exp_res.push_back('{32'd10, 5'b01000});
    run_op(32'd1, 32'd9, 32'd3, 5'd4, 1'b0, 2'b00, 2'b00, {32'hBB, 32'hAA});
    alu_val = 32'd0; alu_fv = 4'b0001;
    exp_ops.push_back('{32'hBB, 32'd3, 5'd5});
    exp_res.push_back('{32'd0, 5'b00010});
    run_op(32'd1, 32'd9, 32'd3, 5'd5, 1'b1, 2'b10, 2'b11, {32'hBB, 32'hAA});

    // timeout, then late done in HOLD and IDLE
    alu_delay = -1; res_ready = 1'b0;
    exp_ops.push_back('{32'd5, 32'd7, 5'd6});
    exp_res.push_back('{32'd0, 5'b00011});
    send(32'd5, 32'd0, 32'd7, 5'd6, 1'b1, 2'b00, 2'b00, 64'd0);
    wait_start(n);
    wait_rv(n);
    chk("tmo_cycles", n, 9);
    chk("tmo_err_tmo", {error_flag, timeout_flag}, 2'b11);
    @(posedge soc_clk); #1 spur_req++;
    @(negedge soc_clk);
    @(negedge soc_clk);
    chk("late_hold_rv", res_valid, 1'b1);
    chk("late_hold_data", result_data, 32'd0);
    chk("late_hold_flags", {overflow_flag, zero_flag, condition_met_flag, error_flag, timeout_flag}, 5'b00011);
    @(posedge soc_clk); #1 res_ready = 1'b1;
    @(posedge soc_clk); #1 spur_req++;
    @(negedge soc_clk);
    @(negedge soc_clk);
    chk("late_idle_ready", in_ready, 1'b1);
    chk("late_idle_rv", res_valid, 1'b0);
    chk("late_idle_keep", {result_data, error_flag, timeout_flag}, {32'd0, 2'b11});
    chk("late_idle_start", alu_start, 1'b0);

    // done on the last allowed WAIT cycle wins
    alu_delay = 8; alu_val = 32'h55; alu_fv = 4'b1000;
    exp_ops.push_back('{32'd2, 32'd4, 5'd7});
    exp_res.push_back('{32'h55, 5'b10000});
    send(32'd2, 32'd4, 32'd0, 5'd7, 1'b0, 2'b00, 2'b00, 64'd0);
    wait_start(n);
    wait_rv(n);
    chk("done8_cycles", n, 9);
    chk("done8_tmo", timeout_flag, 1'b0);
    @(negedge soc_clk);

    // stall in IDLE blocks acceptance
    EX_stall = 1'b1; in_valid = 1'b1; rs1_data = 32'hEE;
    repeat (3) begin
      @(negedge soc_clk);
      chk("stall_idle_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0; EX_stall = 1'b0;
    repeat (3) begin
      @(negedge soc_clk);
      chk("stall_no_start", alu_start, 1'b0);
    end

    // stall in RESOLVE delays start by 3 cycles, stall in HOLD keeps result
    alu_delay = 1; alu_val = 32'h77; alu_fv = 4'b0000;
    exp_ops.push_back('{32'd7, 32'd8, 5'd9});
    exp_res.push_back('{32'h77, 5'b00000});
    @(posedge soc_clk); #1 res_ready = 1'b0;
    send(32'd7, 32'd8, 32'd0, 5'd9, 1'b0, 2'b00, 2'b00, 64'd0);
    EX_stall = 1'b1;
    n = 0;
    repeat (3) begin
      @(negedge soc_clk); n++;
      chk("stall_res_start", alu_start, 1'b0);
    end
    @(posedge soc_clk); #1 EX_stall = 1'b0;
    wait_start(m);
    chk("stall_lat", n + m, 5);
    wait_rv(n);
    EX_stall = 1'b1;
    repeat (2) begin
      @(negedge soc_clk);
      chk("stall_hold", {res_valid, result_data}, {1'b1, 32'h77});
    end
    EX_stall = 1'b0;
    @(posedge soc_clk); #1 res_ready = 1'b1;
    @(negedge soc_clk);
    @(negedge soc_clk);
    chk("stall_idle", in_ready, 1'b1);

    // backpressure
    alu_val = 32'hDEADBEEF;
    exp_ops.push_back('{32'h10, 32'h20, 5'd1});
    exp_res.push_back('{32'hDEADBEEF, 5'b00000});
    @(posedge soc_clk); #1 res_ready = 1'b0;
    send(32'h10, 32'h20, 32'd0, 5'd1, 1'b0, 2'b00, 2'b00, 64'd0);
    wait_start(n);
    wait_rv(n);
    repeat (5) begin
      @(negedge soc_clk);
      chk("bp_hold", {in_ready, res_valid, result_data}, {2'b01, 32'hDEADBEEF});
    end
    @(posedge soc_clk); #1 res_ready = 1'b1;
    @(negedge soc_clk);
    @(negedge soc_clk);
    chk("bp_idle", {in_ready, res_valid, result_data}, {2'b10, 32'hDEADBEEF});

    // reset in WAIT, done arrives the cycle after
    alu_delay = 3;
    exp_ops.push_back('{32'd3, 32'd4, 5'd2});
    send(32'd3, 32'd4, 32'd0, 5'd2, 1'b0, 2'b00, 2'b00, 64'd0);
    wait_start(n);
    @(negedge soc_clk);
    @(negedge soc_clk);
    EX_reset = 1'b1;
    @(negedge soc_clk);
    EX_reset = 1'b0;
    chk("mrst_rv", res_valid, 1'b0);
    chk("mrst_ops", {alu_dat1, alu_dat2}, 64'd0);
    chk("mrst_res", {alu_op, alu_start, result_data}, 38'd0);
    chk("mrst_flags", {overflow_flag, zero_flag, condition_met_flag, error_flag, timeout_flag}, 5'b0);
    @(negedge soc_clk);
    chk("mrst_done_ign", {in_ready, res_valid, alu_start}, 3'b100);
    chk("mrst_done_data", result_data, 32'd0);
    @(negedge soc_clk);
    chk("mrst_still_idle", {in_ready, res_valid}, 2'b10);

    chk("ops_drained", exp_ops.size(), 0);
    chk("res_drained", exp_res.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
